button_event_ctrl: RTL and testbench

//  Avalon-MM slave controller for the push-button input port. Synchronises and debounces
//  the raw button lines, detects press/release events, latches them in an edge-capture

---
 rtl/button_event_ctrl.sv | 140 ++++++++++++++
 tb/tb_button_event_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Push-button port controller: synchronises and debounces raw button pins, captures
// press/release events in a sticky register and drives a maskable level interrupt.
module button_event_ctrl #(
    parameter int WIDTH      = 4,
    parameter int DEBOUNCE   = 50000,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    // Avalon-MM slave: write is qualified by chipselect; reads have a fixed
    // one-cycle latency with no waitrequest, readdata reloads on every clock.
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    // One bit per line, high while that line's debouncer is counting.
    output logic [WIDTH-1:0] dbg_counting_o
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_e;

    localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] evt;
    deb_state_e       fsm_q [WIDTH];
    deb_state_e       fsm_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] cap_set, cap_clr;
    logic             wr;
    logic             unused_wdata;

    assign pressed      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign wr           = chipselect & write;
    assign unused_wdata = ^writedata[31:WIDTH];

    always_comb begin
        state_d = state_q;
        evt     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fsm_d[i] = fsm_q[i];
            cnt_d[i] = cnt_q[i];
            case (fsm_q[i])
                ST_STABLE: begin
                    if (pressed[i] != state_q[i]) begin
                        fsm_d[i] = ST_COUNT;
                        cnt_d[i] = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_COUNT: begin
                    if (pressed[i] == state_q[i]) begin
                        fsm_d[i] = ST_STABLE;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = pressed[i];
                        evt[i]     = 1'b1;
                        fsm_d[i]   = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    fsm_d[i] = ST_STABLE;
                    cnt_d[i] = '0;
                end
            endcase
            dbg_counting_o[i] = (fsm_q[i] == ST_COUNT);
        end
    end

    always_comb begin
        mask_d = (wr && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
        ctrl_d = (wr && address == 2'd3) ? writedata[1:0] : ctrl_q;
        // A release event shows up as state_d going to 0, so it only qualifies with BOTH set.
        cap_set = ctrl_q[0] ? (evt & (ctrl_q[1] ? {WIDTH{1'b1}} : state_d)) : '0;
        cap_clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
        ecap_d  = (ecap_q & ~cap_clr) | cap_set;
        irq_d   = |(ecap_q & mask_q);
        case (address)
            2'd0:    readdata_d = 32'(state_q);
            2'd1:    readdata_d = 32'(mask_q);
            2'd2:    readdata_d = 32'(ecap_q);
            default: readdata_d = 32'(ctrl_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            state_q    <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            ctrl_q     <= 2'b01;
            irq_q      <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                fsm_q[i] <= ST_STABLE;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                fsm_q[i] <= fsm_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random pin/bus traffic, every
// cycle compared with a run-length reference model of the debouncer and registers.
module tb_button_event_ctrl;

    localparam int W  = 4;
    localparam int DB = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chipselect = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = {W{1'b1}};
    logic          irq;
    logic [W-1:0]  dbg_counting;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]  m_pin1, m_pin2;
    logic [W-1:0]  m_deb, m_mask, m_ecap;
    logic [1:0]    m_ctrl;
    int            m_run [W];
    logic [31:0]   m_rdata;
    logic          m_irq;

    button_event_ctrl #(
        .WIDTH(W), .DEBOUNCE(DB), .CNT_W(CW), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq), .dbg_counting_o(dbg_counting)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pin1  = {W{1'b1}};
        m_pin2  = {W{1'b1}};
        m_deb   = '0;
        m_mask  = '0;
        m_ecap  = '0;
        m_ctrl  = 2'b01;
        m_rdata = '0;
        m_irq   = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // A line's debounced level flips once the synchronised pin has disagreed with it
    // for DB consecutive clocks; any agreeing clock restarts the run.
    task automatic model_step();
        logic [31:0]  nrd;
        logic         nirq;
        logic [W-1:0] samp, evt, set_v, clr_v;
        case (address)
            2'd0:    nrd = 32'(m_deb);
            2'd1:    nrd = 32'(m_mask);
            2'd2:    nrd = 32'(m_ecap);
            default: nrd = 32'(m_ctrl);
        endcase
        nirq = |(m_ecap & m_mask);
        samp = ~m_pin2;
        evt  = '0;
        for (int i = 0; i < W; i++) begin
            if (samp[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_deb[i] = samp[i];
                    evt[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        set_v = m_ctrl[0] ? (evt & (m_ctrl[1] ? {W{1'b1}} : m_deb)) : '0;
        clr_v = (chipselect && write && address == 2'd2) ? writedata[W-1:0] : '0;
        m_ecap = (m_ecap & ~clr_v) | set_v;
        if (chipselect && write && address == 2'd1) m_mask = writedata[W-1:0];
        if (chipselect && write && address == 2'd3) m_ctrl = writedata[1:0];
        m_pin2  = m_pin1;
        m_pin1  = in_port;
        m_rdata = nrd;
        m_irq   = nirq;
    endtask

    task automatic check_outputs();
        check("readdata_model", readdata, m_rdata);
        check("irq_model", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic settle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs();
            check("reset_dbg", 32'(dbg_counting), 32'd0);
        end
        reset_n = 1'b1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        cyc();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b0;
        cyc();
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values of all four registers
        read_reg(2'd0, rd); check("rst_state", rd, 32'h0);
        read_reg(2'd1, rd); check("rst_mask", rd, 32'h0);
        read_reg(2'd2, rd); check("rst_ecap", rd, 32'h0);
        read_reg(2'd3, rd); check("rst_ctrl", rd, 32'h1);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Press line 0: state flips on the 10th edge, irq follows one edge later
        write_reg(2'd1, 32'h1);
        address = 2'd0;
        in_port = 4'b1110;
        settle(9);
        check("press_early_state", readdata, 32'h0);
        cyc();
        check("press_edge10_state", readdata, 32'h0);
        check("press_edge10_irq", {31'd0, irq}, 32'd0);
        cyc();
        check("press_edge11_state", readdata, 32'h1);
        check("press_edge11_irq", {31'd0, irq}, 32'd1);
        read_reg(2'd2, rd); check("press_ecap", rd, 32'h1);

        // Bouncing line 2 never settles long enough to register
        write_reg(2'd2, 32'hF);
        address = 2'd0;
        for (int c = 0; c < 100; c++) begin
            if (c % 5 == 0) in_port[2] = ~in_port[2];
            cyc();
            check("bounce_state2", {31'd0, readdata[2]}, 32'd0);
        end
        settle(4);
        read_reg(2'd0, rd); check("bounce_state", rd, 32'h1);
        read_reg(2'd2, rd); check("bounce_ecap", rd, 32'h0);
        check("bounce_irq", {31'd0, irq}, 32'd0);

        // Press-only capture, then press-and-release capture on line 1
        write_reg(2'd3, 32'h1);
        write_reg(2'd2, 32'hF);
        in_port[1] = 1'b0; settle(12);
        read_reg(2'd2, rd); check("b0_press_ecap", rd, 32'h2);
        write_reg(2'd2, 32'h2);
        in_port[1] = 1'b1; settle(12);
        read_reg(2'd2, rd); check("b0_release_ignored", rd, 32'h0);
        write_reg(2'd3, 32'hFFFF_FFFF);
        read_reg(2'd3, rd); check("ctrl_implemented_bits", rd, 32'h3);
        in_port[1] = 1'b0; settle(12);
        read_reg(2'd2, rd); check("b1_press_ecap", rd, 32'h2);
        write_reg(2'd2, 32'h2);
        read_reg(2'd2, rd); check("b1_cleared", rd, 32'h0);
        in_port[1] = 1'b1; settle(12);
        read_reg(2'd2, rd); check("b1_release_ecap", rd, 32'h2);
        write_reg(2'd2, 32'hF);

        // Clear racing a fresh event on the same bit: the event wins
        write_reg(2'd1, 32'h1);
        in_port[0] = 1'b1; settle(12);
        check("race_pre_irq", {31'd0, irq}, 32'd1);
        in_port[0] = 1'b0;
        settle(9);
        write_reg(2'd2, 32'h1);
        check("race_irq_a", {31'd0, irq}, 32'd1);
        read_reg(2'd2, rd); check("race_ecap_kept", rd, 32'h1);
        check("race_irq_b", {31'd0, irq}, 32'd1);
        write_reg(2'd2, 32'h1);
        check("clear_irq_same", {31'd0, irq}, 32'd1);
        cyc();
        check("clear_irq_next", {31'd0, irq}, 32'd0);
        read_reg(2'd2, rd); check("clear_ecap", rd, 32'h0);
        write_reg(2'd0, 32'h0);
        read_reg(2'd0, rd); check("state_readonly", rd, 32'h1);

        // Reset in the middle of a count
        in_port = 4'b1111; settle(12);
        in_port = 4'b0111; settle(5);
        check("count_dbg", {31'd0, dbg_counting[3]}, 32'd1);
        do_reset();
        read_reg(2'd0, rd); check("mid_rst_state", rd, 32'h0);
        read_reg(2'd1, rd); check("mid_rst_mask", rd, 32'h0);
        read_reg(2'd2, rd); check("mid_rst_ecap", rd, 32'h0);
        read_reg(2'd3, rd); check("mid_rst_ctrl", rd, 32'h1);
        address = 2'd0;
        settle(6);
        check("mid_rst_edge10_state", readdata, 32'h0);
        cyc();
        check("mid_rst_edge11_state", readdata, 32'h8);

        // Random pin activity and bus traffic against the model
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) in_port[b] = ~in_port[b];
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 7) == 0);
            writedata  = $urandom;
            if (address == 2'd3 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
            cyc();
        end
        chipselect = 1'b0;
        write      = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
